execute_stage: RTL and testbench

- Execute stage of the OTTER 5-stage pipeline. Consumes the decode/execute register outputs (*_E signals).
- Applies operand forwarding, performs the ALU operation, and resolves branches and jumps (target plus redirect request).
- Contains the execute/memory pipeline register, with stall, flush and asynchronous reset, that feeds the memory stage.

---
 rtl/execute_stage.sv | 187 ++++++++++++++++++
 tb/tb_execute_stage.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// OTTER pipeline execute stage: operand forwarding, ALU, branch/jump resolution
// and the EX/MEM pipeline register feeding the memory stage.
module execute_stage #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             stall_M,
  input  logic             flush_M,
  input  logic [WIDTH-1:0] PC_E,
  input  logic [WIDTH-1:0] Instr_E,
  input  logic [WIDTH-1:0] rs1_E,
  input  logic [WIDTH-1:0] rs2_E,
  input  logic [WIDTH-1:0] immed_ext_E,
  input  logic [WIDTH-1:0] PC_plus4_E,
  input  logic             regWrite_E,
  input  logic             memWrite_E,
  input  logic             memRead2_E,
  input  logic             jump_E,
  input  logic             branch_E,
  input  logic             alu_src_E,
  input  logic             alu_srcB_E,
  input  logic [3:0]       alu_fun_E,
  input  logic [1:0]       rf_wr_sel_E,
  input  logic [1:0]       fwdA_sel,
  input  logic [1:0]       fwdB_sel,
  input  logic [WIDTH-1:0] wd_W,
  output logic             pc_src_E,
  output logic [WIDTH-1:0] target_E,
  output logic [WIDTH-1:0] PC_plus4_M,
  output logic [WIDTH-1:0] Instr_M,
  output logic [WIDTH-1:0] alu_result_M,
  output logic [WIDTH-1:0] store_data_M,
  output logic             regWrite_M,
  output logic             memWrite_M,
  output logic             memRead2_M,
  output logic [1:0]       rf_wr_sel_M
);

  localparam logic [6:0] OpJalr = 7'b1100111;

  typedef enum logic [3:0] {
    AluAdd  = 4'b0000,
    AluSll  = 4'b0001,
    AluSlt  = 4'b0010,
    AluSltu = 4'b0011,
    AluXor  = 4'b0100,
    AluSrl  = 4'b0101,
    AluOr   = 4'b0110,
    AluAnd  = 4'b0111,
    AluSub  = 4'b1000,
    AluLui  = 4'b1001,
    AluSra  = 4'b1101
  } alu_op_e;

  logic [WIDTH-1:0] op_a, op_b, src_a, src_b, alu_res, jalr_sum;
  logic [4:0]       shamt;
  logic             br_cond;

  logic [WIDTH-1:0] pc_plus4_q, pc_plus4_d, instr_q, instr_d;
  logic [WIDTH-1:0] alu_result_q, alu_result_d, store_data_q, store_data_d;
  logic             reg_write_q, reg_write_d, mem_write_q, mem_write_d;
  logic             mem_read2_q, mem_read2_d;
  logic [1:0]       rf_wr_sel_q, rf_wr_sel_d;

  // Select 01 forwards the value currently held in EX/MEM, before this edge's update.
  always_comb begin
    op_a = rs1_E;
    op_b = rs2_E;
    if (FWD_EN) begin
      case (fwdA_sel)
        2'b01:   op_a = alu_result_q;
        2'b10:   op_a = wd_W;
        default: op_a = rs1_E;
      endcase
      case (fwdB_sel)
        2'b01:   op_b = alu_result_q;
        2'b10:   op_b = wd_W;
        default: op_b = rs2_E;
      endcase
    end
  end

  assign src_a = alu_src_E  ? PC_E        : op_a;
  assign src_b = alu_srcB_E ? immed_ext_E : op_b;
  assign shamt = src_b[4:0];

  always_comb begin
    alu_res = '0;
    case (alu_op_e'(alu_fun_E))
      AluAdd:  alu_res = src_a + src_b;
      AluSub:  alu_res = src_a - src_b;
      AluSll:  alu_res = src_a << shamt;
      AluSlt:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      AluSltu: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      AluXor:  alu_res = src_a ^ src_b;
      AluSrl:  alu_res = src_a >> shamt;
      AluSra:  alu_res = $unsigned($signed(src_a) >>> shamt);
      AluOr:   alu_res = src_a | src_b;
      AluAnd:  alu_res = src_a & src_b;
      AluLui:  alu_res = src_b;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (Instr_E[14:12])
      3'b000:  br_cond = (op_a == op_b);
      3'b001:  br_cond = (op_a != op_b);
      3'b100:  br_cond = ($signed(op_a) < $signed(op_b));
      3'b101:  br_cond = ($signed(op_a) >= $signed(op_b));
      3'b110:  br_cond = (op_a < op_b);
      3'b111:  br_cond = (op_a >= op_b);
      default: br_cond = 1'b0;
    endcase
  end

  assign jalr_sum = op_a + immed_ext_E;
  assign target_E = (Instr_E[6:0] == OpJalr) ? {jalr_sum[WIDTH-1:1], 1'b0}
                                             : PC_E + immed_ext_E;
  // Suppressed while stalled so the redirect fires only when the instruction leaves E.
  assign pc_src_E = (jump_E | (branch_E & br_cond)) & ~stall_M;

  always_comb begin
    pc_plus4_d   = pc_plus4_q;
    instr_d      = instr_q;
    alu_result_d = alu_result_q;
    store_data_d = store_data_q;
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    mem_read2_d  = mem_read2_q;
    rf_wr_sel_d  = rf_wr_sel_q;
    if (flush_M) begin
      pc_plus4_d   = '0;
      instr_d      = '0;
      alu_result_d = '0;
      store_data_d = '0;
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      mem_read2_d  = 1'b0;
      rf_wr_sel_d  = '0;
    end else if (!stall_M) begin
      pc_plus4_d   = PC_plus4_E;
      instr_d      = Instr_E;
      alu_result_d = alu_res;
      store_data_d = op_b;
      reg_write_d  = regWrite_E;
      mem_write_d  = memWrite_E;
      mem_read2_d  = memRead2_E;
      rf_wr_sel_d  = rf_wr_sel_E;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_plus4_q   <= '0;
      instr_q      <= '0;
      alu_result_q <= '0;
      store_data_q <= '0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read2_q  <= 1'b0;
      rf_wr_sel_q  <= '0;
    end else begin
      pc_plus4_q   <= pc_plus4_d;
      instr_q      <= instr_d;
      alu_result_q <= alu_result_d;
      store_data_q <= store_data_d;
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      mem_read2_q  <= mem_read2_d;
      rf_wr_sel_q  <= rf_wr_sel_d;
    end
  end

  assign PC_plus4_M   = pc_plus4_q;
  assign Instr_M      = instr_q;
  assign alu_result_M = alu_result_q;
  assign store_data_M = store_data_q;
  assign regWrite_M   = reg_write_q;
  assign memWrite_M   = mem_write_q;
  assign memRead2_M   = mem_read2_q;
  assign rf_wr_sel_M  = rf_wr_sel_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: vector table for ALU/branch/forwarding,
// hand sequences for stall, flush and asynchronous reset.
module tb_execute_stage;

  logic        CLK = 1'b0, RST = 1'b1, stall_M = 1'b0, flush_M = 1'b0;
  logic [31:0] PC_E = '0, Instr_E = '0, rs1_E = '0, rs2_E = '0, immed_ext_E = '0;
  logic [31:0] PC_plus4_E = '0, wd_W = '0;
  logic        regWrite_E = 0, memWrite_E = 0, memRead2_E = 0, jump_E = 0, branch_E = 0;
  logic        alu_src_E = 0, alu_srcB_E = 0;
  logic [3:0]  alu_fun_E = '0;
  logic [1:0]  rf_wr_sel_E = '0, fwdA_sel = '0, fwdB_sel = '0;
  logic        pc_src_E, regWrite_M, memWrite_M, memRead2_M;
  logic [31:0] target_E, PC_plus4_M, Instr_M, alu_result_M, store_data_M;
  logic [1:0]  rf_wr_sel_M;

  execute_stage #(.WIDTH(32), .FWD_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .stall_M(stall_M), .flush_M(flush_M),
    .PC_E(PC_E), .Instr_E(Instr_E), .rs1_E(rs1_E), .rs2_E(rs2_E),
    .immed_ext_E(immed_ext_E), .PC_plus4_E(PC_plus4_E),
    .regWrite_E(regWrite_E), .memWrite_E(memWrite_E), .memRead2_E(memRead2_E),
    .jump_E(jump_E), .branch_E(branch_E), .alu_src_E(alu_src_E), .alu_srcB_E(alu_srcB_E),
    .alu_fun_E(alu_fun_E), .rf_wr_sel_E(rf_wr_sel_E), .fwdA_sel(fwdA_sel),
    .fwdB_sel(fwdB_sel), .wd_W(wd_W), .pc_src_E(pc_src_E), .target_E(target_E),
    .PC_plus4_M(PC_plus4_M), .Instr_M(Instr_M), .alu_result_M(alu_result_M),
    .store_data_M(store_data_M), .regWrite_M(regWrite_M), .memWrite_M(memWrite_M),
    .memRead2_M(memRead2_M), .rf_wr_sel_M(rf_wr_sel_M)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [3:0]  fun;
    logic        sa, sb;
    logic [1:0]  fa, fb;
    logic [31:0] pc, instr, rs1, rs2, imm, wdw;
    logic        jump, branch, rw, mw;
    logic        exp_src;
    logic [31:0] exp_tgt, exp_res, exp_st;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic v(input string name, input logic [3:0] fun, input logic sa, input logic sb,
                   input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] pc,
                   input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                   input logic [31:0] imm, input logic [31:0] wdw, input logic jump,
                   input logic branch, input logic rw, input logic mw, input logic exp_src,
                   input logic [31:0] exp_tgt, input logic [31:0] exp_res,
                   input logic [31:0] exp_st);
    vec_t t;
    t.name = name; t.fun = fun; t.sa = sa; t.sb = sb; t.fa = fa; t.fb = fb;
    t.pc = pc; t.instr = instr; t.rs1 = rs1; t.rs2 = rs2; t.imm = imm; t.wdw = wdw;
    t.jump = jump; t.branch = branch; t.rw = rw; t.mw = mw;
    t.exp_src = exp_src; t.exp_tgt = exp_tgt; t.exp_res = exp_res; t.exp_st = exp_st;
    tv.push_back(t);
  endtask

  task automatic drive(input logic [3:0] fun, input logic sa, input logic sb,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [31:0] pc,
                       input logic [31:0] instr, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm,
                       input logic [31:0] wdw, input logic jump, input logic branch,
                       input logic rw, input logic mw);
    alu_fun_E = fun; alu_src_E = sa; alu_srcB_E = sb; fwdA_sel = fa; fwdB_sel = fb;
    PC_E = pc; PC_plus4_E = pc + 32'd4; Instr_E = instr; rs1_E = rs1; rs2_E = rs2;
    immed_ext_E = imm; wd_W = wdw; jump_E = jump; branch_E = branch;
    regWrite_E = rw; memWrite_E = mw; memRead2_E = 1'b0;
    rf_wr_sel_E = rw ? 2'b11 : 2'b00;
  endtask

  initial begin
    //  name       fun   sa sb fa  fb  pc         instr         rs1           rs2
    //             imm           wdW           j  b  rw mw  src tgt        res           st
    v("add",      4'h0, 0, 0, 0, 0, 32'h0,    32'h002081B3, 32'd5,        32'd7,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'd12,       32'd7);
    v("add8",     4'h0, 0, 0, 0, 0, 32'h4,    32'h002081B3, 32'd8,        32'd8,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h4,     32'h10,       32'd8);
    v("sub_fwdA", 4'h8, 0, 0, 1, 0, 32'h8,    32'h402081B3, 32'hDEAD,     32'd3,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h8,     32'h0D,       32'd3);
    v("add_fwdB", 4'h0, 0, 0, 0, 2, 32'hC,    32'h002081B3, 32'h10,       32'h1234,
                  32'h0,        32'hFFFFFFFF, 0, 0, 1, 0,  0, 32'hC,     32'h0F,  32'hFFFFFFFF);
    v("beq_t",    4'h8, 0, 0, 0, 0, 32'h100,  32'h00000063, 32'd9,        32'd9,
                  32'h20,       32'h0,        0, 1, 0, 0,  1, 32'h120,   32'h0,        32'd9);
    v("bne_nt",   4'h8, 0, 0, 0, 0, 32'h100,  32'h00001063, 32'd9,        32'd9,
                  32'h20,       32'h0,        0, 1, 0, 0,  0, 32'h120,   32'h0,        32'd9);
    v("blt_t",    4'h8, 0, 0, 0, 0, 32'h100,  32'h00004063, 32'hFFFFFFFF, 32'd1,
                  32'h20,       32'h0,        0, 1, 0, 0,  1, 32'h120,   32'hFFFFFFFE, 32'd1);
    v("bltu_nt",  4'h8, 0, 0, 0, 0, 32'h100,  32'h00006063, 32'hFFFFFFFF, 32'd1,
                  32'h20,       32'h0,        0, 1, 0, 0,  0, 32'h120,   32'hFFFFFFFE, 32'd1);
    v("bge_nt",   4'h8, 0, 0, 0, 0, 32'h100,  32'h00005063, 32'hFFFFFFFF, 32'd1,
                  32'h20,       32'h0,        0, 1, 0, 0,  0, 32'h120,   32'hFFFFFFFE, 32'd1);
    v("bgeu_t",   4'h8, 0, 0, 0, 0, 32'h100,  32'h00007063, 32'hFFFFFFFF, 32'd1,
                  32'h20,       32'h0,        0, 1, 0, 0,  1, 32'h120,   32'hFFFFFFFE, 32'd1);
    v("bf3_010",  4'h8, 0, 0, 0, 0, 32'h100,  32'h00002063, 32'd9,        32'd9,
                  32'h20,       32'h0,        0, 1, 0, 0,  0, 32'h120,   32'h0,        32'd9);
    v("slt",      4'h2, 0, 0, 0, 0, 32'h10,   32'h0020A1B3, 32'hFFFFFFFF, 32'd1,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h10,    32'd1,        32'd1);
    v("sltu",     4'h3, 0, 0, 0, 0, 32'h10,   32'h0020B1B3, 32'hFFFFFFFF, 32'd1,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h10,    32'd0,        32'd1);
    v("sll",      4'h1, 0, 0, 0, 0, 32'h0,    32'h002091B3, 32'd1,        32'h24,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'h10,       32'h24);
    v("srl",      4'h5, 0, 0, 0, 0, 32'h0,    32'h0020D1B3, 32'h80000000, 32'd4,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'h08000000, 32'd4);
    v("sra",      4'hD, 0, 0, 0, 0, 32'h0,    32'h4020D1B3, 32'h80000000, 32'd4,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'hF8000000, 32'd4);
    v("xor",      4'h4, 0, 0, 0, 0, 32'h0,    32'h0020C1B3, 32'hF0F0,     32'hFF00,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'h0FF0,     32'hFF00);
    v("or",       4'h6, 0, 0, 0, 0, 32'h0,    32'h0020E1B3, 32'hF0F0,     32'hFF00,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'hFFF0,     32'hFF00);
    v("and",      4'h7, 0, 0, 0, 0, 32'h0,    32'h0020F1B3, 32'hF0F0,     32'hFF00,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'hF000,     32'hFF00);
    v("lui",      4'h9, 0, 1, 0, 0, 32'h0,    32'h123451B7, 32'h0,        32'h0,
                  32'h12345000, 32'h0,        0, 0, 1, 0,  0, 32'h12345000, 32'h12345000, 32'h0);
    v("bad_op",   4'hA, 0, 0, 0, 0, 32'h0,    32'h002081B3, 32'd5,        32'd7,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'h0,        32'd7);
    v("auipc",    4'h0, 1, 1, 0, 0, 32'h1000, 32'h00002197, 32'h0,        32'h0,
                  32'h2000,     32'h0,        0, 0, 1, 0,  0, 32'h3000,  32'h3000,     32'h0);
    v("jal",      4'h0, 0, 0, 0, 0, 32'h40,   32'h0000006F, 32'h0,        32'h0,
                  32'h80,       32'h0,        1, 0, 1, 0,  1, 32'hC0,    32'h0,        32'h0);
    v("fwdA_11",  4'h0, 0, 0, 3, 0, 32'h0,    32'h002081B3, 32'd3,        32'd4,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'd7,        32'd4);
    v("fwdB_01",  4'h0, 0, 0, 0, 1, 32'h0,    32'h002081B3, 32'd1,        32'd99,
                  32'h0,        32'h0,        0, 0, 1, 0,  0, 32'h0,     32'd8,        32'd7);
    v("fwdA_10",  4'h0, 0, 0, 2, 0, 32'h0,    32'h002081B3, 32'h0,        32'd1,
                  32'h0,        32'h100,      0, 0, 1, 0,  0, 32'h0,     32'h101,      32'd1);

    #1;
    chk("rst_alu", alu_result_M, 32'h0);
    chk("rst_ctl", {29'd0, regWrite_M, memWrite_M, memRead2_M}, 32'h0);
    chk("rst_instr", Instr_M, 32'h0);
    @(negedge CLK);
    RST = 1'b0;

    foreach (tv[i]) begin
      @(negedge CLK);
      drive(tv[i].fun, tv[i].sa, tv[i].sb, tv[i].fa, tv[i].fb, tv[i].pc, tv[i].instr,
            tv[i].rs1, tv[i].rs2, tv[i].imm, tv[i].wdw, tv[i].jump, tv[i].branch,
            tv[i].rw, tv[i].mw);
      #1;
      chk({tv[i].name, ".pc_src"}, {31'd0, pc_src_E}, {31'd0, tv[i].exp_src});
      chk({tv[i].name, ".target"}, target_E, tv[i].exp_tgt);
      @(posedge CLK);
      #1;
      chk({tv[i].name, ".result"}, alu_result_M, tv[i].exp_res);
      chk({tv[i].name, ".store"}, store_data_M, tv[i].exp_st);
      chk({tv[i].name, ".pc4"}, PC_plus4_M, tv[i].pc + 32'd4);
      chk({tv[i].name, ".instr"}, Instr_M, tv[i].instr);
      chk({tv[i].name, ".ctl"}, {28'd0, regWrite_M, memWrite_M, rf_wr_sel_M},
          {28'd0, tv[i].rw, tv[i].mw, tv[i].rw ? 2'b11 : 2'b00});
    end

    // jalr redirect held off by a two-cycle stall, then fired once
    @(negedge CLK);
    drive(4'h0, 0, 0, 0, 0, 32'h80, 32'h002081B3, 32'd5, 32'd7, 32'h0, 32'h0, 0, 0, 1, 0);
    @(posedge CLK);
    #1 chk("pre_jalr.result", alu_result_M, 32'd12);
    @(negedge CLK);
    drive(4'h0, 0, 1, 0, 0, 32'h200, 32'h00008067, 32'h203, 32'h0, 32'h4, 32'h0, 1, 0, 1, 0);
    #1;
    chk("jalr.pc_src", {31'd0, pc_src_E}, 32'd1);
    chk("jalr.target", target_E, 32'h206);
    stall_M = 1'b1;
    #1 chk("jalr_stall.pc_src", {31'd0, pc_src_E}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(posedge CLK);
      #1;
      chk("stall.result", alu_result_M, 32'd12);
      chk("stall.instr", Instr_M, 32'h002081B3);
      chk("stall.pc4", PC_plus4_M, 32'h84);
      chk("stall.pc_src", {31'd0, pc_src_E}, 32'd0);
    end
    @(negedge CLK);
    stall_M = 1'b0;
    #1 chk("unstall.pc_src", {31'd0, pc_src_E}, 32'd1);
    @(posedge CLK);
    #1;
    chk("jalr.result", alu_result_M, 32'h207);
    chk("jalr.pc4", PC_plus4_M, 32'h204);
    chk("jalr.instr", Instr_M, 32'h00008067);
    @(negedge CLK);
    drive(4'h0, 0, 1, 0, 0, 32'h204, 32'h00000013, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, 0);
    #1 chk("after_jalr.pc_src", {31'd0, pc_src_E}, 32'd0);

    // flush beats stall: a store in E becomes a bubble
    @(negedge CLK);
    drive(4'h0, 0, 1, 0, 0, 32'h300, 32'h0020A023, 32'h100, 32'hAB, 32'h8, 32'h0, 0, 0, 0, 1);
    flush_M = 1'b1;
    stall_M = 1'b1;
    @(posedge CLK);
    #1;
    chk("flush.memWrite", {31'd0, memWrite_M}, 32'd0);
    chk("flush.result", alu_result_M, 32'h0);
    chk("flush.store", store_data_M, 32'h0);
    chk("flush.instr", Instr_M, 32'h0);
    chk("flush.pc4", PC_plus4_M, 32'h0);
    chk("flush.ctl", {29'd0, regWrite_M, rf_wr_sel_M}, 32'h0);
    @(negedge CLK);
    flush_M = 1'b0;
    stall_M = 1'b0;
    @(posedge CLK);
    #1;
    chk("store.memWrite", {31'd0, memWrite_M}, 32'd1);
    chk("store.addr", alu_result_M, 32'h108);
    chk("store.data", store_data_M, 32'hAB);

    // asynchronous reset mid-cycle, then held across edges
    @(negedge CLK);
    drive(4'h0, 0, 0, 0, 0, 32'h400, 32'h002081B3, 32'h50, 32'd5, 32'h0, 32'h0, 0, 0, 1, 0);
    @(posedge CLK);
    #1 chk("pre_rst.result", alu_result_M, 32'h55);
    #2 RST = 1'b1;
    #1;
    chk("async_rst.result", alu_result_M, 32'h0);
    chk("async_rst.ctl", {30'd0, regWrite_M, rf_wr_sel_M[0]}, 32'h0);
    chk("async_rst.pc4", PC_plus4_M, 32'h0);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      drive(4'h0, 0, 0, 0, 0, 32'h500, 32'h002081B3, 32'(c + 1), 32'd10, 32'h0, 32'h0,
            0, 0, 1, 1);
      @(posedge CLK);
      #1;
      chk("rst_hold.result", alu_result_M, 32'h0);
      chk("rst_hold.ctl", {30'd0, regWrite_M, memWrite_M}, 32'h0);
    end
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK);
    #1 chk("rst_release.result", alu_result_M, 32'd13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
